// File: rtl/wb_address_pipe_if.sv
// -----------------------------------------------------------------------------
// wb_address_pipe_if
//   Bundles the issue-side and register-file-side signals of wb_address_pipe.
//   master : decode / testbench side (drives the issue fields, sees the results)
//   slave  : wb_address_pipe side
//
//   Issue side   : issue_valid, issue_we, select, reg_field0, reg_field1,
//                  rs0, rs0_used, rs1, rs1_used, flush, ex_data -> stall
//   Write port   : rf_we, rf_waddr, rf_wdata
//   Debug        : stall_count
// -----------------------------------------------------------------------------
interface wb_address_pipe_if #(
   parameter int AW  = 2,
   parameter int DW  = 8,
   parameter int SCW = 8
);
   logic           issue_valid;
   logic           issue_we;
   logic [1:0]     select;
   logic [AW-1:0]  reg_field0;
   logic [AW-1:0]  reg_field1;
   logic [AW-1:0]  rs0;
   logic           rs0_used;
   logic [AW-1:0]  rs1;
   logic           rs1_used;
   logic           flush;
   logic [DW-1:0]  ex_data;
   logic           stall;
   logic           rf_we;
   logic [AW-1:0]  rf_waddr;
   logic [DW-1:0]  rf_wdata;
   logic [SCW-1:0] stall_count;

   modport master (
      output issue_valid, issue_we, select, reg_field0, reg_field1,
             rs0, rs0_used, rs1, rs1_used, flush, ex_data,
      input  stall, rf_we, rf_waddr, rf_wdata, stall_count
   );

   modport slave (
      input  issue_valid, issue_we, select, reg_field0, reg_field1,
             rs0, rs0_used, rs1, rs1_used, flush, ex_data,
      output stall, rf_we, rf_waddr, rf_wdata, stall_count
   );
endinterface

// File: rtl/wb_address_pipe.sv
// -----------------------------------------------------------------------------
// wb_address_pipe
//   Decodes the destination register of the issuing instruction, carries it
//   through an EX/WB pipeline next to the result data, drives the register
//   file write port, raises the issue stall on read-after-write hazards
//   against in-flight destinations and counts stall cycles (saturating).
//
//   Ports
//     clk      : rising-edge clock
//     reset_n  : asynchronous active-low reset
//     bus      : wb_address_pipe_if.slave (issue fields, stall, rf write port,
//                stall_count)
//
//   Build option
//     ZERO_REG_EN : register 0 is hardwired zero (never written, never a
//                   hazard source). Undefined: register 0 is ordinary.
// -----------------------------------------------------------------------------
module wb_address_pipe #(
   parameter int AW       = 2,
   parameter int DW       = 8,
   parameter int LINK_REG = 2,
   parameter int SCW      = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   wb_address_pipe_if.slave bus
);

   localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

   logic [AW-1:0]  dest_addr;
   logic           hit0;
   logic           hit1;
   logic           stall_int;
   logic           accept;
   logic           ex_load_valid;

   logic           ex_valid;
   logic [AW-1:0]  ex_addr;
   logic           wb_valid;
   logic [AW-1:0]  wb_addr;
   logic [DW-1:0]  wb_data;
   logic [SCW-1:0] stall_count;

   // Destination decode.
   always_comb begin
      // NOTE: assign a default before the case so no path leaves dest_addr
      // unassigned; otherwise synthesis infers a latch.
      dest_addr = '0;
      case (bus.select)
         2'd1:    dest_addr = bus.reg_field0;
         2'd2:    dest_addr = bus.reg_field1;
         2'd3:    dest_addr = LINK_ADDR;
         default: dest_addr = '0;
      endcase
   end

   // Hazard detection. Both EX and WB count: the register file is not
   // write-through, so a source being written this very cycle still stalls.
   always_comb begin
      hit0 = (ex_valid && (ex_addr == bus.rs0)) || (wb_valid && (wb_addr == bus.rs0));
      hit1 = (ex_valid && (ex_addr == bus.rs1)) || (wb_valid && (wb_addr == bus.rs1));
`ifdef ZERO_REG_EN
      if (bus.rs0 == '0) hit0 = 1'b0;
      if (bus.rs1 == '0) hit1 = 1'b0;
`endif
      // A flush kills the issuing instruction anyway, so there is nothing
      // to hold back.
      stall_int = bus.issue_valid && !bus.flush &&
                  ((bus.rs0_used && hit0) || (bus.rs1_used && hit1));
   end

   assign accept = bus.issue_valid && !stall_int;

   always_comb begin
      ex_load_valid = accept && bus.issue_we && !bus.flush;
`ifdef ZERO_REG_EN
      if (dest_addr == '0) ex_load_valid = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: address and data stages are cleared too (not just the
         // valid bits) so the write port reads all-zero straight out of reset.
         ex_valid    <= 1'b0;
         ex_addr     <= '0;
         wb_valid    <= 1'b0;
         wb_addr     <= '0;
         wb_data     <= '0;
         stall_count <= '0;
      end else begin
         // NOTE: non-blocking assignments so WB samples the EX values from
         // before this edge, giving a true two-stage shift.
         ex_valid <= ex_load_valid;
         ex_addr  <= dest_addr;
         // A flush kills what is in EX right now; WB takes a bubble instead.
         wb_valid <= ex_valid && !bus.flush;
         wb_addr  <= ex_addr;
         wb_data  <= bus.ex_data;
         if (stall_int && (stall_count != '1))
            stall_count <= stall_count + SCW'(1);
      end
   end

   assign bus.stall       = stall_int;
   assign bus.rf_we       = wb_valid;
   assign bus.rf_waddr    = wb_addr;
   assign bus.rf_wdata    = wb_data;
   assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_wb_address_pipe.sv
// -----------------------------------------------------------------------------
// tb_wb_address_pipe
//   Self-checking bench for wb_address_pipe (default parameters).
//   Inputs change 1 time unit after the rising edge; outputs are compared on
//   the falling edge. Cycle table first, then reset-in-flight, post-reset
//   latency and stall counter saturation sequences.
// -----------------------------------------------------------------------------
module tb_wb_address_pipe;

   localparam int AW  = 2;
   localparam int DW  = 8;
   localparam int SCW = 8;
`ifdef ZERO_REG_EN
   localparam bit ZE = 1'b1;
`else
   localparam bit ZE = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;
   int   exp_cnt  = 0;

   always #5 clk = ~clk;

   wb_address_pipe_if #(.AW(AW), .DW(DW), .SCW(SCW)) bus ();

   wb_address_pipe #(.AW(AW), .DW(DW), .LINK_REG(2), .SCW(SCW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic          iv;
      logic          we;
      logic [1:0]    sel;
      logic [AW-1:0] f0;
      logic [AW-1:0] f1;
      logic [AW-1:0] rs0;
      logic          u0;
      logic [AW-1:0] rs1;
      logic          u1;
      logic          fl;
      logic [DW-1:0] data;
      logic          e_stall;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(
      input logic iv, input logic we, input logic [1:0] sel,
      input logic [AW-1:0] f0, input logic [AW-1:0] f1,
      input logic [AW-1:0] rs0, input logic u0,
      input logic [AW-1:0] rs1, input logic u1,
      input logic fl, input logic [DW-1:0] data,
      input logic es, input logic ewe,
      input logic [AW-1:0] ea, input logic [DW-1:0] ed);
      vec_t t;
      t.iv = iv; t.we = we; t.sel = sel; t.f0 = f0; t.f1 = f1;
      t.rs0 = rs0; t.u0 = u0; t.rs1 = rs1; t.u1 = u1; t.fl = fl;
      t.data = data; t.e_stall = es; t.e_we = ewe; t.e_addr = ea; t.e_data = ed;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      bus.issue_valid = t.iv;
      bus.issue_we    = t.we;
      bus.select      = t.sel;
      bus.reg_field0  = t.f0;
      bus.reg_field1  = t.f1;
      bus.rs0         = t.rs0;
      bus.rs0_used    = t.u0;
      bus.rs1         = t.rs1;
      bus.rs1_used    = t.u1;
      bus.flush       = t.fl;
      bus.ex_data     = t.data;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t idle;
      idle = v(0,0,0, 0,0, 0,0,0,0, 0, 8'h00, 0,0,0,0);
      drive(idle);
      reset_n = 1'b0;

      // --- reset state ----------------------------------------------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rf_we",       bus.rf_we,       0);
      check("rst_rf_waddr",    bus.rf_waddr,    0);
      check("rst_rf_wdata",    bus.rf_wdata,    0);
      check("rst_stall_count", bus.stall_count, 0);
      #1 reset_n = 1'b1;
      next_cycle();

      // --- cycle table ----------------------------------------------------
      //        iv we sel f0 f1 rs0 u0 rs1 u1 fl data    stall we addr data
      // basic write r3, data 0xA5 follows one cycle later
      vecs.push_back(v(1,1,1, 3,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'hA5, 0,0,0,0));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'h00, 0,1,3,8'hA5));
      // select sweep 0..3 with f0=1 f1=3 -> writes 0,1,3,2 back to back
      vecs.push_back(v(1,1,0, 1,3, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(1,1,1, 1,3, 0,0,0,0, 0, 8'hD0, 0,0,0,0));
      vecs.push_back(v(1,1,2, 1,3, 0,0,0,0, 0, 8'hD1, 0,!ZE,0,8'hD0));
      vecs.push_back(v(1,1,3, 1,3, 0,0,0,0, 0, 8'hD2, 0,1,1,8'hD1));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'hD3, 0,1,3,8'hD2));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'h00, 0,1,2,8'hD3));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      // rs0 hazard on r1: two stall cycles (EX hit, then WB hit while writing)
      vecs.push_back(v(1,1,1, 1,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(1,0,0, 0,0, 1,1,0,0, 0, 8'h77, 1,0,0,0));
      vecs.push_back(v(1,0,0, 0,0, 1,1,0,0, 0, 8'h00, 1,1,1,8'h77));
      vecs.push_back(v(1,0,0, 0,0, 1,1,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      // rs1 hazard on r3 (rs0 equal but unused)
      vecs.push_back(v(1,1,2, 0,3, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(1,0,0, 0,0, 3,0,3,1, 0, 8'h3C, 1,0,0,0));
      vecs.push_back(v(1,0,0, 0,0, 3,0,3,1, 0, 8'h00, 1,1,3,8'h3C));
      vecs.push_back(v(1,0,0, 0,0, 3,0,3,1, 0, 8'h00, 0,0,0,0));
      // unused matching source does not stall
      vecs.push_back(v(1,1,1, 1,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(1,0,0, 0,0, 1,0,2,1, 0, 8'h11, 0,0,0,0));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'h00, 0,1,1,8'h11));
      // source equal to own destination is not a hazard
      vecs.push_back(v(1,1,1, 3,0, 3,1,0,0, 0, 8'h00, 0,0,0,0));
      // write r2 then flush: r2 never written, dependent read of r2 free
      vecs.push_back(v(1,1,2, 0,2, 0,0,0,0, 0, 8'h33, 0,0,0,0));
      vecs.push_back(v(1,0,0, 0,0, 2,1,0,0, 1, 8'h99, 0,1,3,8'h33));
      vecs.push_back(v(1,0,0, 0,0, 2,1,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      // flush kills EX (r3) while WB (r1) still commits
      vecs.push_back(v(1,1,1, 1,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(1,1,2, 0,3, 0,0,0,0, 0, 8'h5A, 0,0,0,0));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 1, 8'h00, 0,1,1,8'h5A));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      // register 0: ordinary by default, hardwired zero with ZERO_REG_EN
      vecs.push_back(v(1,1,0, 0,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(1,0,0, 0,0, 0,1,0,0, 0, 8'h42, !ZE,0,0,0));
      vecs.push_back(v(1,0,0, 0,0, 0,1,0,0, 0, 8'h00, !ZE,!ZE,0,8'h42));
      vecs.push_back(v(1,0,0, 0,0, 0,1,0,0, 0, 8'h00, 0,0,0,0));
      vecs.push_back(v(0,0,0, 0,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));

      exp_cnt = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         check($sformatf("v%0d_stall", i),       bus.stall,       vecs[i].e_stall);
         check($sformatf("v%0d_rf_we", i),       bus.rf_we,       vecs[i].e_we);
         check($sformatf("v%0d_stall_count", i), bus.stall_count, exp_cnt);
         if (vecs[i].e_we) begin
            check($sformatf("v%0d_rf_waddr", i), bus.rf_waddr, vecs[i].e_addr);
            check($sformatf("v%0d_rf_wdata", i), bus.rf_wdata, vecs[i].e_data);
         end
         if (vecs[i].e_stall && exp_cnt < 255) exp_cnt++;
         next_cycle();
      end

      // --- reset with EX and WB both holding writes -----------------------
      drive(v(1,1,1, 1,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      next_cycle();
      drive(v(1,1,2, 0,2, 0,0,0,0, 0, 8'hA1, 0,0,0,0));
      next_cycle();
      drive(v(0,0,0, 0,0, 0,0,0,0, 0, 8'hB2, 0,0,0,0));
      @(negedge clk);
      check("pre_rst_rf_we",    bus.rf_we,    1);
      check("pre_rst_rf_waddr", bus.rf_waddr, 1);
      #2 reset_n = 1'b0;
      drive(idle);
      #1;
      check("mid_rst_rf_we",       bus.rf_we,       0);
      check("mid_rst_rf_waddr",    bus.rf_waddr,    0);
      check("mid_rst_rf_wdata",    bus.rf_wdata,    0);
      check("mid_rst_stall_count", bus.stall_count, 0);
      @(posedge clk);
      @(negedge clk);
      #1 reset_n = 1'b1;
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_idle%0d_rf_we", i), bus.rf_we, 0);
         next_cycle();
      end

      // --- first write after reset: rf_we two cycles after the issue cycle
      drive(v(1,1,2, 0,3, 0,0,0,0, 0, 8'h00, 0,0,0,0));
      @(negedge clk);
      check("lat_c0_rf_we", bus.rf_we, 0);
      next_cycle();
      drive(v(0,0,0, 0,0, 0,0,0,0, 0, 8'hC3, 0,0,0,0));
      @(negedge clk);
      check("lat_c1_rf_we", bus.rf_we, 0);
      next_cycle();
      drive(idle);
      @(negedge clk);
      check("lat_c2_rf_we",    bus.rf_we,    1);
      check("lat_c2_rf_waddr", bus.rf_waddr, 3);
      check("lat_c2_rf_wdata", bus.rf_wdata, 8'hC3);
      next_cycle();
      @(negedge clk);
      check("lat_c3_rf_we", bus.rf_we, 0);
      next_cycle();

      // --- stall counter saturation: 150 x (write r1, read r1 x3) ---------
      exp_cnt = 0;
      for (int it = 0; it < 150; it++) begin
         drive(v(1,1,1, 1,0, 0,0,0,0, 0, 8'h00, 0,0,0,0));
         @(negedge clk);
         check($sformatf("sat%0d_w_stall", it), bus.stall, 0);
         next_cycle();
         for (int k = 0; k < 3; k++) begin
            drive(v(1,0,0, 0,0, 1,1,0,0, 0, 8'h00, 0,0,0,0));
            @(negedge clk);
            check($sformatf("sat%0d_%0d_stall", it, k), bus.stall, (k < 2) ? 1 : 0);
            check($sformatf("sat%0d_%0d_count", it, k), bus.stall_count, exp_cnt);
            if (k < 2 && exp_cnt < 255) exp_cnt++;
            next_cycle();
         end
      end
      drive(idle);
      @(negedge clk);
      check("sat_final_count", bus.stall_count, 8'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always ends with a summary.
   initial begin
      #200000;
      failures++;
      $display("FAIL timeout: got no finish expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
